// File: rtl/inst_loader_pkg.sv
// Shared constants and state encoding for the instruction loader.
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM trailer check).
package inst_loader_pkg;

  // Word-address width of INST_BRAM; capacity is 2**INST_SIZE words.
  localparam int unsigned INST_SIZE = 4;

  // Core mode encodings.
  localparam logic [2:0] MODE_STALL = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_EXEC  = 3'd2;

  // Loader FSM state encoding.
  typedef logic [2:0] loader_state_t;
  localparam loader_state_t StIdle = 3'd0;
  localparam loader_state_t StHdr  = 3'd1;
  localparam loader_state_t StData = 3'd2;
  localparam loader_state_t StCsum = 3'd3;
  localparam loader_state_t StDone = 3'd4;
  localparam loader_state_t StErr  = 3'd5;

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Collects four bytes, MSB first, into a 32-bit word. word_valid_o fires
// combinationally with the 4th byte; clr_i discards any partial word.
module inst_loader_word_assembler (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q;
  logic [23:0] shift_q;

  // Completed word is the three held bytes plus the byte on the input.
  always_comb begin
    word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    word_o       = {shift_q, byte_i};
  end

  // Byte counter wraps naturally after each full word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[15:0], byte_i};
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: parses the UART byte stream (header N, then N words,
// all big-endian) and writes the words into INST_BRAM.
// Optional feature macro: LOADER_CHECKSUM_EN (XOR trailer checked in CSUM).
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_SIZE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        mode_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_ferr_i,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [31:0]       bram_din_o,
  output logic              bram_we_o,
  output logic              load_done_o,
  output logic              load_err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [31:0] MaxWords = 32'd1 << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              done_q, err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic        active, mode_load;
  logic        asm_clr, asm_valid;
  logic        word_valid;
  logic [31:0] word;

  // Bytes only reach the assembler while loading; a framing error or mode
  // exit throws away whatever partial word is held.
  always_comb begin
    active    = (state_q == StHdr) || (state_q == StData) || (state_q == StCsum);
    mode_load = (mode_i == MODE_LOAD);
    asm_valid = active && mode_load && rx_valid_i && !rx_ferr_i;
    asm_clr   = !active || !mode_load || rx_ferr_i;
  end

  inst_loader_word_assembler u_asm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (asm_clr),
    .byte_valid_i (asm_valid),
    .byte_i       (rx_data_i),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Loader FSM and BRAM write generation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      StIdle: if (mode_load) state_d = StHdr;
      StHdr, StData, StCsum: begin
        if (!mode_load) begin
          // Abort: words already written stay in BRAM, no flag is raised.
          state_d = StIdle;
          idx_d   = '0;
          n_d     = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end else if (rx_ferr_i) begin
          state_d = StErr;
        end else if (word_valid) begin
          if (state_q == StHdr) begin
            if (word == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
`endif
            end else if (word > MaxWords) begin
              state_d = StErr;
            end else begin
              n_d     = word[ADDR_W:0];
              state_d = StData;
            end
          end else if (state_q == StData) begin
            we_d   = 1'b1;
            addr_d = idx_q[ADDR_W-1:0];
            din_d  = word;
            idx_d  = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_d = csum_q ^ word;
            if (idx_d == n_q) state_d = StCsum;
`else
            if (idx_d == n_q) state_d = StDone;
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          else begin
            state_d = (word == csum_q) ? StDone : StErr;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  // State registers; flags trail the terminal state by one cycle so that
  // load_done follows the final write pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      n_q     <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= (state_q == StDone);
      err_q   <= (state_q == StErr);
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign bram_addr_o    = addr_q;
  assign bram_din_o     = din_q;
  assign bram_we_o      = we_q;
  assign load_done_o    = done_q;
  assign load_err_o     = err_q;
  assign words_loaded_o = idx_q;

endmodule
